div_unit: RTL and testbench



---
 rtl/div_unit_if.sv | 22 ++
 rtl/div_unit.sv | 125 ++++++++++++
 tb/tb_div_unit.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/div_unit_if.sv
// Request/response bundle between the EXE-stage ALU (master) and the iterative divider (slave).
interface div_unit_if #(parameter int DIV_W = 32);
    logic             div_req;
    logic             div_signed;
    logic [DIV_W-1:0] div_src1;
    logic [DIV_W-1:0] div_src2;
    logic             div_cancel;
    logic             div_busy;
    logic             div_done;
    logic [DIV_W-1:0] div_quot;
    logic [DIV_W-1:0] div_rem;

    modport master (
        output div_req, div_signed, div_src1, div_src2, div_cancel,
        input  div_busy, div_done, div_quot, div_rem
    );

    modport slave (
        input  div_req, div_signed, div_src1, div_src2, div_cancel,
        output div_busy, div_done, div_quot, div_rem
    );
endinterface

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider returning quotient and remainder for div/divu/mod/modu.
// Optional macro DIV_ZERO_FAST_EN: a zero divisor skips the iterations and completes one cycle after acceptance.
module div_unit #(
    parameter int DIV_W = 32
) (
    input logic        clk,
    input logic        reset,
    div_unit_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state;
    logic [5:0]       cnt;
    logic [DIV_W-1:0] dvd;
    logic [DIV_W-1:0] dsr;
    logic [DIV_W-1:0] src1_raw;
    logic [DIV_W:0]   part;
    logic             q_neg;
    logic             r_neg;
    logic             zero_div;

    logic             s1;
    logic             s2;
    logic [DIV_W-1:0] mag1;
    logic [DIV_W-1:0] mag2;
    logic [DIV_W:0]   shifted;
    logic [DIV_W:0]   diff;
    logic             q_bit;
    logic [DIV_W:0]   part_next;
    logic [DIV_W-1:0] quot_next;
    logic [DIV_W-1:0] quot_fix;
    logic [DIV_W-1:0] rem_fix;

    // dvd doubles as the quotient register: dividend bits leave at the top as quotient bits enter at the bottom
    always_comb begin
        s1        = bus.div_signed & bus.div_src1[DIV_W-1];
        s2        = bus.div_signed & bus.div_src2[DIV_W-1];
        mag1      = s1 ? (~bus.div_src1 + 1'b1) : bus.div_src1;
        mag2      = s2 ? (~bus.div_src2 + 1'b1) : bus.div_src2;
        shifted   = {part[DIV_W-1:0], dvd[DIV_W-1]};
        diff      = shifted - {1'b0, dsr};
        q_bit     = ~diff[DIV_W];
        part_next = q_bit ? diff : shifted;
        quot_next = {dvd[DIV_W-2:0], q_bit};
        quot_fix  = q_neg ? (~quot_next + 1'b1) : quot_next;
        rem_fix   = r_neg ? (~part_next[DIV_W-1:0] + 1'b1) : part_next[DIV_W-1:0];
        if (zero_div) begin
            quot_fix = '1;
            rem_fix  = src1_raw;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            dvd          <= '0;
            dsr          <= '0;
            src1_raw     <= '0;
            part         <= '0;
            q_neg        <= 1'b0;
            r_neg        <= 1'b0;
            zero_div     <= 1'b0;
            bus.div_busy <= 1'b0;
            bus.div_done <= 1'b0;
            bus.div_quot <= '0;
            bus.div_rem  <= '0;
        end else begin
            bus.div_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.div_req && !bus.div_cancel) begin
                        dvd          <= mag1;
                        dsr          <= mag2;
                        src1_raw     <= bus.div_src1;
                        part         <= '0;
                        q_neg        <= s1 ^ s2;
                        r_neg        <= s1;
                        zero_div     <= (bus.div_src2 == '0);
                        cnt          <= '0;
                        bus.div_busy <= 1'b1;
`ifdef DIV_ZERO_FAST_EN
                        if (bus.div_src2 == '0) begin
                            bus.div_quot <= '1;
                            bus.div_rem  <= bus.div_src1;
                            bus.div_done <= 1'b1;
                            state        <= DONE;
                        end else begin
                            state        <= CALC;
                        end
`else
                        state        <= CALC;
`endif
                    end
                end
                CALC: begin
                    if (bus.div_cancel) begin
                        state        <= IDLE;
                        bus.div_busy <= 1'b0;
                    end else begin
                        dvd  <= quot_next;
                        part <= part_next;
                        cnt  <= cnt + 6'd1;
                        if (cnt == 6'(DIV_W - 1)) begin
                            bus.div_quot <= quot_fix;
                            bus.div_rem  <= rem_fix;
                            bus.div_done <= 1'b1;
                            state        <= DONE;
                        end
                    end
                end
                DONE: begin
                    state        <= IDLE;
                    bus.div_busy <= 1'b0;
                end
                default: begin
                    state        <= IDLE;
                    bus.div_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed corner cases plus random operands against an arithmetic model.
`timescale 1ns/1ps
module tb_div_unit;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    div_unit_if #(.DIV_W(32)) bus ();

    div_unit #(.DIV_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", tag, actual, expected);
        end
    endtask

    // Reference behaviour: plain 64-bit arithmetic sidesteps the signed overflow case
    function automatic void refDiv(input logic [31:0] a, input logic [31:0] b, input bit sgn,
                                   output logic [31:0] q, output logic [31:0] r);
        longint sa, sb, lq, lr;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            lq = sa / sb;
            lr = sa % sb;
            q  = lq[31:0];
            r  = lr[31:0];
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    function automatic int expLatency(input logic [31:0] b);
`ifdef DIV_ZERO_FAST_EN
        if (b == 32'd0) return 1;
`endif
        return 33;
    endfunction

    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input bit sgn);
        logic [31:0] eq, er;
        int lat, busy_cnt, exp_lat;
        refDiv(a, b, sgn, eq, er);
        exp_lat  = expLatency(b);
        lat      = 0;
        busy_cnt = 0;
        @(posedge clk); #1;
        bus.div_req    = 1'b1;
        bus.div_signed = sgn;
        bus.div_src1   = a;
        bus.div_src2   = b;
        @(posedge clk); #1;
        bus.div_req    = 1'b0;
        bus.div_src1   = $urandom;
        bus.div_src2   = $urandom;
        bus.div_signed = 1'($urandom_range(0, 1));
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (bus.div_busy) busy_cnt++;
            if (bus.div_done) begin
                lat = k;
                break;
            end
        end
        checkOutput("latency", 32'(lat), 32'(exp_lat));
        checkOutput("quot", bus.div_quot, eq);
        checkOutput("rem", bus.div_rem, er);
        checkOutput("busy_cycles", 32'(busy_cnt), 32'(exp_lat));
        @(negedge clk);
        checkOutput("busy_after", 32'(bus.div_busy), 32'd0);
        checkOutput("done_pulse", 32'(bus.div_done), 32'd0);
    endtask

    initial begin
        logic [31:0] ra, rb, hq, hr;
        int lat, done_cnt;
        bit rs;
        checks = 0;
        errors = 0;
        bus.div_req    = 1'b0;
        bus.div_signed = 1'b0;
        bus.div_src1   = '0;
        bus.div_src2   = '0;
        bus.div_cancel = 1'b0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("rst_busy", 32'(bus.div_busy), 32'd0);
        checkOutput("rst_done", 32'(bus.div_done), 32'd0);
        checkOutput("rst_quot", bus.div_quot, 32'd0);
        checkOutput("rst_rem", bus.div_rem, 32'd0);
        reset = 1'b0;

        applyStimulus(32'd100, 32'd7, 1'b0);
        applyStimulus(32'hFFFF_FFF9, 32'd2, 1'b1);
        applyStimulus(32'd7, 32'hFFFF_FFFE, 1'b1);
        applyStimulus(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        applyStimulus(32'hFFFF_FFFF, 32'd1, 1'b0);
        applyStimulus(32'h1234_5678, 32'd0, 1'b1);
        applyStimulus(32'h1234_5678, 32'd0, 1'b0);
        applyStimulus(32'h8765_4321, 32'd0, 1'b1);

        // Cancel on the 10th CALC cycle of 1000/3, after a completed 100/7
        applyStimulus(32'd100, 32'd7, 1'b0);
        @(posedge clk); #1;
        bus.div_req  = 1'b1;
        bus.div_src1 = 32'd1000;
        bus.div_src2 = 32'd3;
        @(posedge clk); #1;
        bus.div_req = 1'b0;
        repeat (9) @(posedge clk);
        #1 bus.div_cancel = 1'b1;
        @(negedge clk);
        checkOutput("cancel_busy_before", 32'(bus.div_busy), 32'd1);
        @(posedge clk); #1;
        bus.div_cancel = 1'b0;
        @(negedge clk);
        checkOutput("cancel_busy_after", 32'(bus.div_busy), 32'd0);
        checkOutput("cancel_quot_hold", bus.div_quot, 32'd14);
        checkOutput("cancel_rem_hold", bus.div_rem, 32'd2);
        done_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.div_done) done_cnt++;
        end
        checkOutput("cancel_no_done", 32'(done_cnt), 32'd0);
        applyStimulus(32'd9, 32'd3, 1'b0);

        // Request held high through a whole operation: re-accepted only once back in IDLE
        @(posedge clk); #1;
        bus.div_req    = 1'b1;
        bus.div_signed = 1'b0;
        bus.div_src1   = 32'd50;
        bus.div_src2   = 32'd6;
        @(posedge clk);
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (bus.div_done) begin
                lat = k;
                break;
            end
        end
        checkOutput("held_latency", 32'(lat), 32'd33);
        checkOutput("held_quot", bus.div_quot, 32'd8);
        checkOutput("held_rem", bus.div_rem, 32'd2);
        @(negedge clk);
        checkOutput("held_idle_gap", 32'(bus.div_busy), 32'd0);
        @(negedge clk);
        checkOutput("held_reaccept", 32'(bus.div_busy), 32'd1);
        @(posedge clk); #1;
        bus.div_req = 1'b0;
        repeat (5) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        checkOutput("midreset_busy", 32'(bus.div_busy), 32'd0);
        checkOutput("midreset_done", 32'(bus.div_done), 32'd0);
        checkOutput("midreset_quot", bus.div_quot, 32'd0);
        checkOutput("midreset_rem", bus.div_rem, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        done_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.div_done) done_cnt++;
        end
        checkOutput("midreset_no_done", 32'(done_cnt), 32'd0);

        for (int n = 0; n < 24; n++) begin
            ra = $urandom;
            rs = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 4))
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 15));
                2:       rb = -32'($urandom_range(1, 15));
                default: rb = $urandom;
            endcase
            applyStimulus(ra, rb, rs);
        end
        refDiv(32'd0, 32'd5, 1'b1, hq, hr);
        applyStimulus(32'd0, 32'd5, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
